// File: rtl/ntt_pkg.sv
// Shared NTT constants and the Solinas-style reduction used by the butterflies.
package ntt_pkg;

  localparam int unsigned DATA_W       = 28;
  localparam logic [DATA_W-1:0] Q      = 28'd268369921;  // 2^28 - 2^16 + 1
  localparam int unsigned DEF_MULT_LAT = 5;
  localparam int unsigned TBL_N        = 32;

  typedef logic [DATA_W-1:0] tw_tbl_t [TBL_N];

  // Reduce a 56-bit product mod q by folding 2^28 == 2^16 - 1 three times.
  // The last fold lands below 2q, so one conditional subtract finishes it.
  function automatic logic [DATA_W-1:0] mul_reduce(input logic [2*DATA_W-1:0] p,
                                                   input logic [DATA_W-1:0]   q);
    logic [44:0] t1;
    logic [33:0] t2;
    logic [28:0] t3;
    logic [28:0] t3_sub;
    t1 = {17'd0, p[27:0]} + {1'b0, p[55:28], 16'd0} - {17'd0, p[55:28]};
    t2 = {6'd0, t1[27:0]} + {1'b0, t1[44:28], 16'd0} - {17'd0, t1[44:28]};
    t3 = {1'b0, t2[27:0]} + {7'd0, t2[33:28], 16'd0} - {23'd0, t2[33:28]};
    t3_sub = t3 - {1'b0, q};
    return (t3 >= {1'b0, q}) ? t3_sub[27:0] : t3[27:0];
  endfunction

endpackage

// File: rtl/mod_add.sv
// Combinational modular addition, operands in [0, q-1].
module mod_add
  import ntt_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_s
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_red;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  assign w_red = w_sum - {1'b0, Q};
  assign o_s   = (w_sum >= {1'b0, Q}) ? w_red[DATA_W-1:0] : w_sum[DATA_W-1:0];

endmodule

// File: rtl/mod_halve.sv
// Multiply by 2^-1 mod q: add q when odd, then shift right; registered output.
module mod_halve
  import ntt_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_a,
  output logic [DATA_W-1:0] o_h
);

  logic [DATA_W:0] w_sum;

  assign w_sum = {1'b0, i_a} + (i_a[0] ? {1'b0, Q} : '0);

  // Register the halved value; the sum is even so the shift is exact
  always_ff @(posedge clk) begin
    if (rst) o_h <= '0;
    else     o_h <= w_sum[DATA_W:1];
  end

endmodule

// File: rtl/mod_sub.sv
// Combinational modular subtraction, operands in [0, q-1].
module mod_sub
  import ntt_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_d
);

  logic [DATA_W:0] w_diff;
  logic [DATA_W:0] w_fix;

  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  // On borrow, adding q in the same width brings the wrapped value back into range
  assign w_fix  = w_diff + {1'b0, Q};
  assign o_d    = (i_a >= i_b) ? w_diff[DATA_W-1:0] : w_fix[DATA_W-1:0];

endmodule

// File: rtl/modular_mult.sv
// Pipelined modular multiplier: product reduced in the first stage, then delayed to LAT.
module modular_mult
  import ntt_pkg::*;
#(
  parameter int unsigned LAT = DEF_MULT_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [DATA_W-1:0] i_q,
  output logic [DATA_W-1:0] o_p
);

  logic [DATA_W-1:0] r_p [LAT];

  // Reduce and shift the result through LAT register stages
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) r_p[i] <= '0;
    end else begin
      r_p[0] <= mul_reduce(i_a * i_b, i_q);
      for (int i = 1; i < LAT; i++) r_p[i] <= r_p[i-1];
    end
  end

  assign o_p = r_p[LAT-1];

endmodule

// File: rtl/gs_butterfly.sv
// Gentleman-Sande butterfly: x' = x+y, y' = (x-y)*w mod q, optional halving.
module gs_butterfly
  import ntt_pkg::*;
#(
  parameter tw_tbl_t     FACTORS  = '{default: 28'd1},
  parameter int unsigned NF       = 32,
  parameter int unsigned REPEAT   = 1,
  parameter int unsigned MULT_LAT = DEF_MULT_LAT,
  parameter bit          HALVE    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] y_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] x_out,
  output logic [DATA_W-1:0] y_out
);

  logic [7:0]        r_rep;
  logic [4:0]        r_idx;
  logic [DATA_W-1:0] w_s, w_d, w_p;
  logic [DATA_W-1:0] r_s, r_d, r_w;
  logic              r_va;
  logic [DATA_W-1:0] r_sdly [MULT_LAT];
  logic              r_vdly [MULT_LAT];
  logic [DATA_W-1:0] w_xh, w_yh;
  logic              w_vh;
  logic [DATA_W-1:0] r_x, r_y;
  logic              r_v;

  // Twiddle sequencing advances on valid beats only, so bubbles do not shift it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rep <= '0;
      r_idx <= '0;
    end else if (in_valid) begin
      if (r_rep == 8'(REPEAT - 1)) begin
        r_rep <= '0;
        r_idx <= (r_idx == 5'(NF - 1)) ? '0 : r_idx + 5'd1;
      end else begin
        r_rep <= r_rep + 8'd1;
      end
    end
  end

  mod_add u_add (.i_a(x_in), .i_b(y_in), .o_s(w_s));
  mod_sub u_sub (.i_a(x_in), .i_b(y_in), .o_d(w_d));

  // Stage A: sum, difference and the twiddle for this beat
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s  <= '0;
      r_d  <= '0;
      r_w  <= '0;
      r_va <= 1'b0;
    end else begin
      r_s  <= w_s;
      r_d  <= w_d;
      r_w  <= FACTORS[r_idx];
      r_va <= in_valid;
    end
  end

  modular_mult #(.LAT(MULT_LAT)) u_mult (
    .clk(clk), .rst(rst), .i_a(r_d), .i_b(r_w), .i_q(Q), .o_p(w_p)
  );

  // Stage M: keep the sum and valid aligned with the multiplier output
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MULT_LAT; i++) begin
        r_sdly[i] <= '0;
        r_vdly[i] <= 1'b0;
      end
    end else begin
      r_sdly[0] <= r_s;
      r_vdly[0] <= r_va;
      for (int i = 1; i < MULT_LAT; i++) begin
        r_sdly[i] <= r_sdly[i-1];
        r_vdly[i] <= r_vdly[i-1];
      end
    end
  end

  if (HALVE) begin : g_halve
    logic r_vh;
    mod_halve u_hx (.clk(clk), .rst(rst), .i_a(r_sdly[MULT_LAT-1]), .o_h(w_xh));
    mod_halve u_hy (.clk(clk), .rst(rst), .i_a(w_p), .o_h(w_yh));
    // Stage H valid tracks the halving registers
    always_ff @(posedge clk) begin
      if (rst) r_vh <= 1'b0;
      else     r_vh <= r_vdly[MULT_LAT-1];
    end
    assign w_vh = r_vh;
  end else begin : g_nohalve
    assign w_xh = r_sdly[MULT_LAT-1];
    assign w_yh = w_p;
    assign w_vh = r_vdly[MULT_LAT-1];
  end

  // Stage O: output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
      r_v <= 1'b0;
    end else begin
      r_x <= w_xh;
      r_y <= w_yh;
      r_v <= w_vh;
    end
  end

  assign x_out     = r_x;
  assign y_out     = r_y;
  assign out_valid = r_v;

endmodule

// File: tb/tb_gs_butterfly.sv
// Scoreboard bench: three butterfly configurations share one random stream.
module tb_gs_butterfly;
  import ntt_pkg::*;

  localparam longint unsigned QL   = 64'd268369921;
  localparam longint unsigned INV2 = (QL + 1) / 2;

  localparam tw_tbl_t F0 = '{0: 28'd1, 1: 28'd2, 2: 28'd3, 3: 28'd4, 4: 28'd5, 5: 28'd6,
                             6: 28'd7, 7: 28'd8, default: 28'd0};
  localparam tw_tbl_t F1 = '{0: 28'd10, 1: 28'd20, 2: 28'd30, 3: 28'd40, default: 28'd7};
  localparam tw_tbl_t F2 = '{0: 28'd1, 1: 28'd268369920, 2: 28'd12345678, default: 28'd99};

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [27:0] x_in, y_in;
  logic        ov [3];
  logic [27:0] xo [3];
  logic [27:0] yo [3];

  always #5 clk = ~clk;

  gs_butterfly #(.FACTORS(F0), .NF(8), .REPEAT(2), .MULT_LAT(5), .HALVE(1'b0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x_in(x_in), .y_in(y_in),
    .out_valid(ov[0]), .x_out(xo[0]), .y_out(yo[0])
  );
  gs_butterfly #(.FACTORS(F1), .NF(4), .REPEAT(1), .MULT_LAT(5), .HALVE(1'b0)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x_in(x_in), .y_in(y_in),
    .out_valid(ov[1]), .x_out(xo[1]), .y_out(yo[1])
  );
  gs_butterfly #(.FACTORS(F2), .NF(3), .REPEAT(3), .MULT_LAT(5), .HALVE(1'b1)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x_in(x_in), .y_in(y_in),
    .out_valid(ov[2]), .x_out(xo[2]), .y_out(yo[2])
  );

  typedef struct {
    longint unsigned t;
    logic [27:0]     x;
    logic [27:0]     y;
  } exp_t;

  exp_t            sbq [3][$];
  longint unsigned cyc = 0;
  int              nbeat [3];
  int              n_cmp = 0;
  int              n_err = 0;
  bit              mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint unsigned lat(input int d);
    return (d == 2) ? 64'd8 : 64'd7;
  endfunction

  // Twiddle for the n-th valid beat since reset
  function automatic longint unsigned twid(input int d, input int n);
    case (d)
      0:       return 64'(F0[(n / 2) % 8]);
      1:       return 64'(F1[n % 4]);
      default: return 64'(F2[(n / 3) % 3]);
    endcase
  endfunction

  function automatic void check(input int d, input string nm,
                                input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL u%0d %s: got %0d want %0d (cycle %0d)", d, nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [27:0] rv();
    int unsigned r;
    r = $urandom_range(7, 0);
    if (r == 0) return 28'd0;
    if (r == 1) return 28'(QL - 1);
    return 28'($urandom_range(32'(QL - 1), 0));
  endfunction

  task automatic push_all(input logic [27:0] x, input logic [27:0] y);
    longint unsigned s, df, yv;
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      s  = (64'(x) + 64'(y)) % QL;
      df = (64'(x) + QL - 64'(y)) % QL;
      yv = (df * twid(d, nbeat[d])) % QL;
      if (d == 2) begin
        s  = (s * INV2) % QL;
        yv = (yv * INV2) % QL;
      end
      e.t = cyc;
      e.x = 28'(s);
      e.y = 28'(yv);
      sbq[d].push_back(e);
      nbeat[d]++;
    end
  endtask

  task automatic beat(input bit v, input logic [27:0] x, input logic [27:0] y);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = v;
    x_in     = x;
    y_in     = y;
    if (v) push_all(x, y);
  endtask

  // One reset cycle with a valid beat presented alongside it (must be ignored)
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    x_in     = rv();
    y_in     = rv();
    for (int d = 0; d < 3; d++) begin
      nbeat[d] = 0;
      while (sbq[d].size() > 0 && sbq[d][sbq[d].size()-1].t + lat(d) > cyc)
        void'(sbq[d].pop_back());
    end
  endtask

  // Monitor: pop and compare whenever a DUT presents a result
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      for (int d = 0; d < 3; d++) begin
        if (ov[d]) begin
          if (sbq[d].size() == 0) begin
            check(d, "spurious_valid", 64'd1, 64'd0);
          end else begin
            e = sbq[d].pop_front();
            check(d, "latency", cyc, e.t + lat(d));
            check(d, "x_out", 64'(xo[d]), 64'(e.x));
            check(d, "y_out", 64'(yo[d]), 64'(e.y));
          end
        end else if (sbq[d].size() != 0 && sbq[d][0].t + lat(d) <= cyc) begin
          e = sbq[d].pop_front();
          check(d, "missing_valid", 64'd0, 64'd1);
        end
      end
    end
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    x_in     = '0;
    y_in     = '0;
    for (int d = 0; d < 3; d++) nbeat[d] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check(d, "reset_out_valid", 64'(ov[d]), 64'd0);
      check(d, "reset_x_out", 64'(xo[d]), 64'd0);
      check(d, "reset_y_out", 64'(yo[d]), 64'd0);
    end
    mon_en = 1'b1;

    // Basic beat, then the modular wrap cases
    beat(1'b1, 28'd5, 28'd3);
    repeat (10) beat(1'b0, '0, '0);
    beat(1'b1, 28'd2, 28'd5);
    beat(1'b1, 28'd268369920, 28'd1);
    repeat (10) beat(1'b0, '0, '0);

    // Twiddle sequencing with a bubble after the third beat
    do_reset();
    repeat (3) beat(1'b1, 28'd1, 28'd0);
    beat(1'b0, '0, '0);
    repeat (3) beat(1'b1, 28'd1, 28'd0);
    repeat (10) beat(1'b0, '0, '0);

    // Index wrap over the whole table
    do_reset();
    repeat (5) beat(1'b1, 28'd1, 28'd0);
    repeat (10) beat(1'b0, '0, '0);

    // Reset with beats in flight
    repeat (3) beat(1'b1, rv(), rv());
    do_reset();
    beat(1'b1, 28'd1, 28'd0);
    repeat (12) beat(1'b0, '0, '0);

    // Random traffic with occasional bubbles and resets
    repeat (400) begin
      if ($urandom_range(63, 0) == 0) do_reset();
      else beat($urandom_range(3, 0) != 0, rv(), rv());
    end
    repeat (15) beat(1'b0, '0, '0);

    for (int d = 0; d < 3; d++) check(d, "queue_drained", 64'(sbq[d].size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
